// File: rtl/bus_arb_if.sv
// ============================================================================
//  Module      : bus_arb_if
//  Description : CPU request, slave response and arbiter result signals
//                shared between the KS10 CPU side, the slaves and bus_arb.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface bus_arb_if #(
    parameter int NSLV = 4,
    parameter int DW   = 36,
    parameter int AW   = 22
) ();

    // CPU request side
    logic                cpuREAD;
    logic                cpuWRITE;
    logic                cpuIO;
    logic [AW-1:0]       cpuADDR;
    logic                nxmCLR;

    // Slave response side
    logic [NSLV-1:0]     slvACK;
    logic [NSLV*DW-1:0]  slvDATA;

    // Arbiter results
    logic                arbACK;
    logic [DW-1:0]       arbDATA;
    logic                arbTMO;
    logic                arbNXMIRQ;
    logic                arbIOERR;
    logic                arbMULTACK;
    logic [AW-1:0]       arbNXMADDR;
    logic                arbBUSY;

    // Drives requests and slave responses, observes the arbiter
    modport master (
        output cpuREAD, cpuWRITE, cpuIO, cpuADDR, nxmCLR, slvACK, slvDATA,
        input  arbACK, arbDATA, arbTMO, arbNXMIRQ, arbIOERR, arbMULTACK,
               arbNXMADDR, arbBUSY
    );

    // The arbiter itself
    modport slave (
        input  cpuREAD, cpuWRITE, cpuIO, cpuADDR, nxmCLR, slvACK, slvDATA,
        output arbACK, arbDATA, arbTMO, arbNXMIRQ, arbIOERR, arbMULTACK,
               arbNXMADDR, arbBUSY
    );

endinterface

`default_nettype wire

// File: rtl/bus_arb.sv
// ============================================================================
//  Module      : bus_arb
//  Description : Registered KS10 bus arbiter and response checker with
//                priority data select, single ack per request and NXM timeout.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module bus_arb #(
    parameter int NSLV = 4,
    parameter int DW   = 36,
    parameter int AW   = 22,
    parameter int TMO  = 15
) (
    input  logic          clk,
    input  logic          rst,
    bus_arb_if.slave      bus
);

    localparam int            CW         = $clog2(TMO) + 1;
    localparam logic [CW-1:0] c_TMO_LAST = CW'(TMO - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            io_q;
    logic [AW-1:0]   addr_q;
    logic            ack_q;
    logic            tmo_q;
    logic [DW-1:0]   data_q;
    logic            nxm_q;
    logic            ioerr_q;
    logic            mult_q;
    logic [AW-1:0]   nxmaddr_q;
    logic            busy_q;

    logic            w_req;
    logic            w_any_ack;
    logic            w_multi_ack;
    logic [NSLV-1:0] w_ack_m1;
    logic [DW-1:0]   w_win_data;

    always_comb begin
        w_req       = bus.cpuREAD | bus.cpuWRITE;
        w_any_ack   = |bus.slvACK;
        // Clearing the lowest set bit leaves something only if two or more were set
        w_ack_m1    = bus.slvACK - NSLV'(1);
        w_multi_ack = |(bus.slvACK & w_ack_m1);
        cnt_d       = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
    end

    // Scan from the lowest priority upward so index 0 overrides everything
    always_comb begin
        w_win_data = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if (bus.slvACK[i]) begin
                w_win_data = bus.slvDATA[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            io_q      <= 1'b0;
            addr_q    <= '0;
            ack_q     <= 1'b0;
            tmo_q     <= 1'b0;
            data_q    <= '0;
            nxm_q     <= 1'b0;
            ioerr_q   <= 1'b0;
            mult_q    <= 1'b0;
            nxmaddr_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            tmo_q <= 1'b0;

            // Later set assignments in this block override the clear
            if (bus.nxmCLR) begin
                nxm_q   <= 1'b0;
                ioerr_q <= 1'b0;
                mult_q  <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (w_req) begin
                        io_q    <= bus.cpuIO;
                        addr_q  <= bus.cpuADDR;
                        state_q <= ST_WAIT;
                        busy_q  <= 1'b1;
                    end
                end

                ST_WAIT: begin
                    if (!w_req) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (w_any_ack) begin
                        state_q <= ST_DONE;
                        ack_q   <= 1'b1;
                        data_q  <= w_win_data;
                        if (w_multi_ack) begin
                            mult_q <= 1'b1;
                        end
                    end else if (cnt_q == c_TMO_LAST) begin
                        state_q   <= ST_DONE;
                        tmo_q     <= 1'b1;
                        data_q    <= '0;
                        nxmaddr_q <= addr_q;
                        if (io_q) begin
                            ioerr_q <= 1'b1;
                        end else begin
                            nxm_q   <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                // Park here until the CPU drops the request: one ack per request
                ST_DONE: begin
                    if (!w_req) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.arbACK     = ack_q;
    assign bus.arbTMO     = tmo_q;
    assign bus.arbDATA    = data_q;
    assign bus.arbNXMIRQ  = nxm_q;
    assign bus.arbIOERR   = ioerr_q;
    assign bus.arbMULTACK = mult_q;
    assign bus.arbNXMADDR = nxmaddr_q;
    assign bus.arbBUSY    = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_arb.sv
// ============================================================================
//  Module      : tb_bus_arb
//  Description : Directed self-checking bench for bus_arb (NSLV=4, TMO=15).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bus_arb;

    localparam int NSLV = 4;
    localparam int DW   = 36;
    localparam int AW   = 22;
    localparam int TMO  = 15;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_errors;

    // Per-transaction observations; cycle 0 is the first cycle the request is driven
    int          cyc;
    int          ack_seen;
    int          ack_cyc;
    logic [35:0] ack_data;
    int          tmo_seen;
    int          tmo_cyc;
    logic [35:0] tmo_data;

    bus_arb_if #(.NSLV(NSLV), .DW(DW), .AW(AW)) bif ();

    bus_arb #(
        .NSLV (NSLV),
        .DW   (DW),
        .AW   (AW),
        .TMO  (TMO)
    ) dut (
        .clk  (clk),
        .rst  (rst_n),
        .bus  (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (bif.arbACK) begin
            if (ack_seen == 0) begin
                ack_cyc  = cyc;
                ack_data = bif.arbDATA;
            end
            ack_seen++;
        end
        if (bif.arbTMO) begin
            if (tmo_seen == 0) begin
                tmo_cyc  = cyc;
                tmo_data = bif.arbDATA;
            end
            tmo_seen++;
        end
    endtask

    task automatic clr_pulse();
        bif.nxmCLR = 1'b1;
        tick();
        bif.nxmCLR = 1'b0;
        tick();
    endtask

    // Request held for cycles 0..hold, slaves ack with pattern over [ack_from, ack_to]
    task automatic txn(input logic rd, input logic wr, input logic io,
                       input logic [21:0] addr, input logic [3:0] ackpat,
                       input int ack_from, input int ack_to,
                       input int clr_at, input int hold);
        cyc      = 0;
        ack_seen = 0;
        ack_cyc  = -1;
        ack_data = '0;
        tmo_seen = 0;
        tmo_cyc  = -1;
        tmo_data = '1;
        bif.cpuREAD  = rd;
        bif.cpuWRITE = wr;
        bif.cpuIO    = io;
        bif.cpuADDR  = addr;
        bif.slvACK   = (ack_from <= 0 && ack_to >= 0) ? ackpat : 4'b0000;
        bif.nxmCLR   = (clr_at == 0);
        repeat (hold) begin
            tick();
            bif.slvACK = (cyc >= ack_from && cyc <= ack_to) ? ackpat : 4'b0000;
            bif.nxmCLR = (cyc == clr_at);
        end
        bif.cpuREAD  = 1'b0;
        bif.cpuWRITE = 1'b0;
        bif.slvACK   = '0;
        bif.nxmCLR   = 1'b0;
        tick();
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ack"},   bif.arbACK,     1'b0);
        check_eq({tag, "_tmo"},   bif.arbTMO,     1'b0);
        check_eq({tag, "_nxm"},   bif.arbNXMIRQ,  1'b0);
        check_eq({tag, "_ioerr"}, bif.arbIOERR,   1'b0);
        check_eq({tag, "_mult"},  bif.arbMULTACK, 1'b0);
        check_eq({tag, "_busy"},  bif.arbBUSY,    1'b0);
        check_eq({tag, "_data"},  bif.arbDATA,    36'd0);
        check_eq({tag, "_naddr"}, bif.arbNXMADDR, 22'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        ack_seen = 0;
        tmo_seen = 0;
        rst_n        = 1'b0;
        bif.cpuREAD  = 1'b0;
        bif.cpuWRITE = 1'b0;
        bif.cpuIO    = 1'b0;
        bif.cpuADDR  = '0;
        bif.nxmCLR   = 1'b0;
        bif.slvACK   = '0;
        bif.slvDATA  = '0;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Memory read, slave 0 answers in cycle 3
        bif.slvDATA[0 +: 36] = 36'o123456701234;
        txn(1'b1, 1'b0, 1'b0, 22'h01234, 4'b0001, 3, 3, -1, 8);
        check_eq("rd_ack_count", ack_seen, 1);
        check_eq("rd_ack_cycle", ack_cyc, 4);
        check_eq("rd_ack_data",  ack_data, 36'o123456701234);
        check_eq("rd_no_tmo",    tmo_seen, 0);
        check_eq("rd_nxm",       bif.arbNXMIRQ, 1'b0);
        check_eq("rd_mult",      bif.arbMULTACK, 1'b0);
        check_eq("rd_busy_end",  bif.arbBUSY, 1'b0);

        // Memory read to unmapped address, nobody answers
        txn(1'b1, 1'b0, 1'b0, 22'h3FFFF, 4'b0000, -1, -1, -1, 20);
        check_eq("nxm_tmo_count", tmo_seen, 1);
        check_eq("nxm_tmo_cycle", tmo_cyc, TMO + 1);
        check_eq("nxm_tmo_data",  tmo_data, 36'd0);
        check_eq("nxm_no_ack",    ack_seen, 0);
        check_eq("nxm_irq",       bif.arbNXMIRQ, 1'b1);
        check_eq("nxm_ioerr",     bif.arbIOERR, 1'b0);
        check_eq("nxm_addr",      bif.arbNXMADDR, 22'h3FFFF);
        clr_pulse();
        check_eq("nxm_cleared",   bif.arbNXMIRQ, 1'b0);
        check_eq("nxm_addr_hold", bif.arbNXMADDR, 22'h3FFFF);

        // IO write timeout
        txn(1'b0, 1'b1, 1'b1, 22'h00100, 4'b0000, -1, -1, -1, 20);
        check_eq("io_tmo_cycle", tmo_cyc, TMO + 1);
        check_eq("io_ioerr",     bif.arbIOERR, 1'b1);
        check_eq("io_nxm",       bif.arbNXMIRQ, 1'b0);
        check_eq("io_addr",      bif.arbNXMADDR, 22'h00100);
        clr_pulse();
        check_eq("io_cleared",   bif.arbIOERR, 1'b0);

        // Timeout and clear on the same edge: the set must win
        txn(1'b0, 1'b1, 1'b1, 22'h00200, 4'b0000, -1, -1, TMO, 20);
        check_eq("io_clr_tmo_cycle", tmo_cyc, TMO + 1);
        check_eq("io_clr_set_wins",  bif.arbIOERR, 1'b1);

        // Two slaves answer at once; slave 1 outranks slave 2
        bif.slvDATA[0   +: 36] = 36'o777;
        bif.slvDATA[36  +: 36] = 36'd1;
        bif.slvDATA[72  +: 36] = 36'd2;
        bif.slvDATA[108 +: 36] = 36'o555;
        txn(1'b1, 1'b0, 1'b0, 22'h00040, 4'b0110, 2, 2, -1, 6);
        check_eq("multi_ack_count", ack_seen, 1);
        check_eq("multi_ack_cycle", ack_cyc, 3);
        check_eq("multi_data",      ack_data, 36'd1);
        check_eq("multi_flag",      bif.arbMULTACK, 1'b1);

        // Reset pulled in the middle of a WAIT
        bif.cpuREAD = 1'b1;
        bif.cpuADDR = 22'h00077;
        tick();
        tick();
        check_eq("wait_busy", bif.arbBUSY, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        bif.cpuREAD = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Held request with ACK held high throughout: one ack, minimum latency
        bif.slvDATA[0 +: 36] = 36'o707070707070;
        txn(1'b1, 1'b0, 1'b0, 22'h00010, 4'b0001, 0, 20, -1, 20);
        check_eq("held_ack_count", ack_seen, 1);
        check_eq("held_ack_cycle", ack_cyc, 2);
        check_eq("held_ack_data",  ack_data, 36'o707070707070);
        check_eq("held_no_tmo",    tmo_seen, 0);
        check_eq("held_mult",      bif.arbMULTACK, 1'b0);

        // ACKs with no request pending must be ignored
        txn(1'b0, 1'b0, 1'b0, 22'h00000, 4'b1111, 0, 6, -1, 6);
        check_eq("idle_ack_none",  ack_seen, 0);
        check_eq("idle_tmo_none",  tmo_seen, 0);
        check_eq("idle_mult",      bif.arbMULTACK, 1'b0);
        check_eq("idle_busy",      bif.arbBUSY, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bus_arb.md
# bus_arb

Registered, parametrised bus arbiter and response checker between the KS10 CPU and its NSLV bus slaves (memory, console, Unibus adapters, ...). It samples each CPU read/write/IO request and tracks it with a transaction state machine. It selects the responding slave's data by priority, returns one registered acknowledge per request, and detects non-existent memory/IO by timeout. A bus cycle that no slave answers can no longer hang the CPU.

## Interface
Parameters:
- NSLV, 4: number of slave ports (1..8); index 0 has highest priority.
- DW, 36: data width.
- AW, 22: address width (cpuADDR bits 14:35).
- TMO, 15: no-acknowledge timeout in WAIT cycles (2..255).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpuREAD  in  1  read request (level, held until completion).
- cpuWRITE  in  1  write request (level); with cpuREAD high it forms a read-modify-write cycle.
- cpuIO  in  1  request is an IO cycle (0 means memory cycle).
- cpuADDR  in  AW  request address.
- slvACK  in  NSLV  per-slave acknowledge.
- slvDATA  in  NSLV*DW  slave read data; slave i occupies bits [i*DW +: DW].
- nxmCLR  in  1  clears the sticky error flags.
- arbACK  out  1  one-cycle acknowledge to the CPU.
- arbDATA  out  DW  registered read data, valid while arbACK or arbTMO is high.
- arbTMO  out  1  one-cycle timeout completion; no slave answered.
- arbNXMIRQ  out  1  sticky non-existent-memory interrupt.
- arbIOERR  out  1  sticky IO timeout flag.
- arbMULTACK  out  1  sticky flag: more than one slave acknowledged in the same cycle.
- arbNXMADDR  out  AW  address of the most recent timed-out cycle.
- arbBUSY  out  1  high in WAIT and DONE.

## Operation
- req = cpuREAD | cpuWRITE.
- FSM states:
  - IDLE
    - req=1 → WAIT.
    - Latch cpuIO into ioReg and cpuADDR into addrReg; clear the counter.
  - WAIT
    - Any slvACK bit set → DONE.
      - Winner = lowest set index.
      - arbDATA ← slvDATA of the winner; arbACK=1 next cycle.
      - If popcount(slvACK) > 1, set arbMULTACK.
    - Otherwise the counter increments. On the cycle it equals TMO-1 → DONE:
      - arbTMO=1 next cycle; arbDATA ← 0; arbNXMADDR ← addrReg.
      - Set arbNXMIRQ if ioReg=0; set arbIOERR if ioReg=1.
    - req drops before completion (aborted cycle) → IDLE; no ack, no error.
  - DONE
    - Stays in DONE while req=1, so a held request is acknowledged exactly once.
    - req=0 → IDLE.
- Slave ACKs arriving in IDLE or DONE are ignored and do not set any flag.
- Sticky flags (arbNXMIRQ, arbIOERR, arbMULTACK) clear only on nxmCLR=1. If a set and nxmCLR occur in the same cycle, the set wins.
- arbNXMADDR holds its value until the next timeout.
- Counter width: clog2(TMO)+1 bits; saturates and never wraps.

## Timing
- Reset (rst=0, asynchronous):
  - FSM=IDLE.
  - arbACK, arbTMO, arbNXMIRQ, arbIOERR, arbMULTACK, arbBUSY = 0.
  - arbDATA = 0, arbNXMADDR = 0, counter = 0.
  - Reset asserted mid-cycle abandons the transaction without an ack.
- Request latency:
  - Request first high at edge k → WAIT after edge k.
  - Slave ACK sampled at edge m > k → arbACK and arbDATA valid for the single cycle after edge m.
  - Minimum request-to-ack latency: 2 cycles.
- Timeout: no ACK for TMO WAIT cycles → arbTMO high exactly TMO+1 cycles after the request was sampled.
- arbACK and arbTMO are mutually exclusive, each one cycle wide, at most one per request.
- arbBUSY = (state != IDLE), registered.
- Back-to-back requests: after req drops, the next request needs at least one IDLE cycle before it is sampled.

## Test plan
- Memory read, TMO=15, NSLV=4: slvACK[0] asserted 3 cycles after the request with slvDATA[0]=36'o123456701234 → arbACK one cycle, arbDATA=36'o123456701234, no flags set.
- Memory read to an unmapped address 0x3FFFF with no ACK → arbTMO at cycle 16, arbNXMIRQ=1, arbNXMADDR=0x3FFFF, arbDATA=0, arbACK never asserted.
- IO write with no ACK → arbTMO, arbIOERR=1, arbNXMIRQ=0. Then nxmCLR pulse → arbIOERR=0. Timeout and nxmCLR in the same cycle → flag remains 1.
- slvACK=4'b0110 in the same cycle, slvDATA[1]=1, slvDATA[2]=2 → arbDATA=1, arbMULTACK=1, a single arbACK.
- Request held 20 cycles with slvACK held high throughout → exactly one arbACK. ACK in IDLE → no output activity.
- rst pulsed low during WAIT → all outputs 0 immediately. The next request completes normally.
